// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and defaults for the piso transmitter
package piso_pkg;

    localparam int PISO_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - loadable shift register with selectable bit order
module piso_shreg #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             head
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load wins over shift so a back-to-back word replaces the last bit cleanly.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            if (LSB_FIRST) begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end else begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Register the shift state; reset clears the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign head = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with optional inter-frame gap
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEF,
    parameter int GAP       = 0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    piso_state_e   state_q;
    piso_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_bit;
    logic          xfer;
    logic          gap_done;
    logic          head;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign xfer     = din_valid && din_ready && !rst;

    // Ready depends only on state and counter, so din never reaches the outputs combinationally.
    always_comb begin
        din_ready = 1'b0;
        if (state_q == ST_IDLE) begin
            din_ready = 1'b1;
        end else if (state_q == ST_SHIFT && last_bit && GAP == 0) begin
            din_ready = 1'b1;
        end
    end

    // Next-state and bit-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (xfer) begin
                        state_d = ST_SHIFT;
                    end else if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and bit-counter registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    if (GAP > 0) begin : g_gap
        localparam int GW = $clog2(GAP + 1);

        logic [GW-1:0] gap_cnt_q;
        logic [GW-1:0] gap_cnt_d;

        // Count idle cycles while in the gap; held at zero everywhere else.
        always_comb begin
            gap_cnt_d = '0;
            if (state_q == ST_GAP) begin
                gap_cnt_d = gap_cnt_q + GW'(1);
            end
        end

        // Gap counter register.
        always_ff @(posedge clk) begin
            if (rst) begin
                gap_cnt_q <= '0;
            end else begin
                gap_cnt_q <= gap_cnt_d;
            end
        end

        assign gap_done = (gap_cnt_q == GW'(GAP - 1));
    end else begin : g_no_gap
        assign gap_done = 1'b1;
    end

    piso_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (xfer),
        .shift (state_q == ST_SHIFT),
        .d     (din),
        .head  (head)
    );

    assign sout_valid  = (state_q == ST_SHIFT);
    assign sout        = sout_valid && head;
    assign frame_start = sout_valid && (cnt_q == '0);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - randomized and directed checks of piso_tx against a frame-timing model
module tb_piso_tx;

    logic       clk;
    logic [7:0] din_a   [3];
    logic       dv_a    [3];
    logic       rst_a   [3];
    logic       rdy_a   [3];
    logic       sout_a  [3];
    logic       sv_a    [3];
    logic       fs_a    [3];
    logic       busy_a  [3];
    logic [3:0] siso_q;

    int         total;
    int         bad;
    int         cyc;
    int         acc_a   [3];
    int         next_a  [3];
    logic [7:0] word_a  [3];

    piso_tx #(.WIDTH(4), .GAP(0), .LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst_a[0]), .din(din_a[0][3:0]), .din_valid(dv_a[0]),
        .din_ready(rdy_a[0]), .sout(sout_a[0]), .sout_valid(sv_a[0]),
        .frame_start(fs_a[0]), .busy(busy_a[0])
    );

    piso_tx #(.WIDTH(8), .GAP(2), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst_a[1]), .din(din_a[1]), .din_valid(dv_a[1]),
        .din_ready(rdy_a[1]), .sout(sout_a[1]), .sout_valid(sv_a[1]),
        .frame_start(fs_a[1]), .busy(busy_a[1])
    );

    piso_tx #(.WIDTH(4), .GAP(1), .LSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst(rst_a[2]), .din(din_a[2][3:0]), .din_valid(dv_a[2]),
        .din_ready(rdy_a[2]), .sout(sout_a[2]), .sout_valid(sv_a[2]),
        .frame_start(fs_a[2]), .busy(busy_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-stage serial-in serial-out register fed by instance 0.
    always @(posedge clk) siso_q <= {siso_q[2:0], sout_a[0]};

    function automatic int pw(input int i);
        return (i == 1) ? 8 : 4;
    endfunction

    function automatic int pg(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int pl(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // One cycle: check outputs against the frame model, drive inputs, advance the model.
    task automatic step(input int i, input logic v, input logic [7:0] d, input logic r,
                        output logic accepted);
        int   w, g, l, dd;
        logic ev, eb;
        w  = pw(i);
        g  = pg(i);
        l  = pl(i);
        dd = cyc - acc_a[i];
        ev = (dd >= 1) && (dd <= w);
        eb = 1'b0;
        if (ev) eb = (l != 0) ? word_a[i][dd-1] : word_a[i][w-dd];
        check_val("sout", int'(sout_a[i]), int'(eb));
        check_val("sout_valid", int'(sv_a[i]), int'(ev));
        check_val("frame_start", int'(fs_a[i]), int'(dd == 1));
        check_val("busy", int'(busy_a[i]), int'((dd >= 1) && (dd <= w + g)));
        check_val("din_ready", int'(rdy_a[i]), int'(cyc >= next_a[i]));
        din_a[i] = d;
        dv_a[i]  = v;
        rst_a[i] = r;
        accepted = v && !r && (cyc >= next_a[i]);
        @(posedge clk);
        if (r) begin
            acc_a[i]  = -100000;
            next_a[i] = cyc + 1;
        end else if (accepted) begin
            acc_a[i]  = cyc;
            word_a[i] = d;
            next_a[i] = (g == 0) ? cyc + w : cyc + w + g + 1;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int i, input int n);
        logic a;
        for (int k = 0; k < n; k++) step(i, 1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic offer(input int i, input logic [7:0] w);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 20) begin
            step(i, 1'b1, w, 1'b0, a);
            n++;
        end
        if (!a) check_val("offer_timeout", 0, 1);
    endtask

    initial begin
        logic       a;
        int         a1, a2;
        logic [3:0] pat;
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int i = 0; i < 3; i++) begin
            dv_a[i]   = 1'b0;
            din_a[i]  = 8'h00;
            rst_a[i]  = 1'b1;
            acc_a[i]  = -100000;
            next_a[i] = 0;
            word_a[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;

        // Single MSB-first frame 1011.
        pat = 4'b1011;
        step(0, 1'b1, 8'h0B, 1'b0, a);
        for (int k = 0; k < 4; k++) begin
            check_val("single_bit", int'(sout_a[0]), int'(pat[3-k]));
            step(0, 1'b0, 8'h00, 1'b0, a);
        end
        idle(0, 2);

        // Downstream SISO reproduces 1100 four cycles later.
        pat = 4'b1100;
        step(0, 1'b1, 8'h0C, 1'b0, a);
        for (int k = 1; k <= 8; k++) begin
            if (k >= 5) check_val("siso_out", int'(siso_q[3]), int'(pat[8-k]));
            step(0, 1'b0, 8'h00, 1'b0, a);
        end

        // Back-to-back words with no gap.
        offer(0, 8'h0A);
        a1 = acc_a[0];
        offer(0, 8'h05);
        a2 = acc_a[0];
        check_val("b2b_spacing", a2 - a1, 4);
        idle(0, 6);

        // LSB-first frames separated by a two-cycle gap.
        offer(1, 8'h01);
        a1 = acc_a[1];
        offer(1, 8'h80);
        a2 = acc_a[1];
        check_val("gap_spacing", a2 - a1, 11);
        idle(1, 12);

        // Reset on the second bit aborts the frame.
        offer(0, 8'h0F);
        step(0, 1'b0, 8'h00, 1'b0, a);
        step(0, 1'b0, 8'h00, 1'b1, a);
        idle(0, 6);

        // Random traffic with din toggling every cycle and occasional reset.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 300; k++) begin
                step(i, ($urandom_range(3) != 0), 8'($urandom()),
                     ($urandom_range(59) == 0), a);
            end
            idle(i, 14);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the parallel word width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter GAP, default 0, meaning the number of idle cycles inserted between consecutive frames.
REQ-003 SHALL have parameter LSB_FIRST, default 0, meaning bit order: 0 = MSB first, 1 = LSB first.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-007 SHALL have port din_valid, input, 1 bit: din holds a word offered for transfer.
REQ-008 SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-009 SHALL have port sout, output, 1 bit: serial data, intended to drive the sin input of the downstream shift-register stage.
REQ-010 SHALL have port sout_valid, output, 1 bit: sout carries a data bit this cycle.
REQ-011 SHALL have port frame_start, output, 1 bit: sout carries the first bit of a frame.
REQ-012 SHALL have port busy, output, 1 bit: a frame or gap is in progress.

Function
REQ-013 SHALL transfer a word on any rising edge where din_valid && din_ready; din SHALL be ignored otherwise.
REQ-014 SHALL implement the states IDLE, SHIFT and GAP.
REQ-015 IDLE: din_ready = 1; on transfer, load the shift register, clear the bit counter, and go to SHIFT.
REQ-016 SHIFT: sout = current head bit, sout_valid = 1, shift by one each cycle, increment the bit counter.
REQ-017 The first bit SHALL appear on sout exactly one cycle after the accepting edge, with frame_start = 1 for that cycle only.
REQ-018 A frame SHALL last exactly WIDTH consecutive sout_valid cycles with no bubbles.
REQ-019 Bit order: with LSB_FIRST = 0, din[WIDTH-1] is sent first; with LSB_FIRST = 1, din[0] is sent first.
REQ-020 On the last bit (counter = WIDTH-1), the next state SHALL be:
- GAP = 0: din_ready = 1 during the last bit. On transfer, go to SHIFT with the new word, so back-to-back frames have zero idle cycles. With no transfer, go to IDLE.
- GAP > 0: din_ready = 0, go to GAP.
REQ-021 GAP: held for exactly GAP cycles with din_ready = 0, then go to IDLE.
REQ-022 When sout_valid = 0, sout SHALL be 0 and frame_start SHALL be 0.
REQ-023 din_ready SHALL be 0 in SHIFT except on the last bit when GAP = 0.
REQ-024 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE.
REQ-025 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-026 The GAP counter SHALL be $clog2(GAP+1) bits wide and SHALL be absent when GAP = 0.
REQ-027 A change of din while din_ready = 0 SHALL NOT affect the frame in flight.
REQ-028 All outputs SHALL be driven from registers or from state decode only; there SHALL be no combinational path from din to sout.

Reset
REQ-029 When rst = 1 at a rising edge, the block SHALL enter IDLE regardless of state, aborting any frame in flight.
REQ-030 Reset values SHALL be: sout = 0, sout_valid = 0, frame_start = 0, busy = 0, din_ready = 1 from the first cycle after reset. The shift register and all counters SHALL be cleared.
REQ-031 A transfer offered on a cycle with rst = 1 SHALL be discarded.

Structure
REQ-032 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT, GAP) and the default width constant PISO_WIDTH_DEF = 4.
REQ-033 One sub-module, piso_shreg, SHALL be used: a loadable, bit-order-selectable shift register (clk, rst, load, shift, d, head). The FSM and counters SHALL stay in piso_tx.

Verification
REQ-034 WIDTH=4, GAP=0, LSB_FIRST=0, din=4'b1011 accepted at cycle 0 -> sout = 1,0,1,1 in cycles 1-4; sout_valid = 1 in cycles 1-4; frame_start = 1 in cycle 1 only; IDLE in cycle 5.
REQ-035 WIDTH=4, GAP=0, din_valid held high with words 4'hA then 4'h5 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; frame_start in cycles 1 and 5; din_ready = 1 in cycle 4.
REQ-036 WIDTH=8, GAP=2, LSB_FIRST=1, two words 8'h01 and 8'h80 offered continuously -> frame 1 sends 1 then seven 0s; 2 cycles with sout_valid = 0 and din_ready = 0; frame 2 starts after one further IDLE acceptance cycle and sends seven 0s then 1.
REQ-037 WIDTH=4, rst asserted on the 2nd bit of frame 4'hF -> next cycle sout = 0, sout_valid = 0, busy = 0, din_ready = 1; the remaining bits are never emitted.
REQ-038 WIDTH=4, din toggled randomly while busy -> the emitted frame equals the accepted word.
REQ-039 piso_tx (WIDTH=4) driving the downstream 4-stage SISO register, word 4'b1100 -> after 4 more cycles the SISO output reproduces 1,1,0,0.
